// File: rtl/life_ctrl.sv
// Pac-Man life controller: ghost contact detection, lives, respawn freeze and game-over.
// Optional post-respawn invulnerability is enabled by defining LIFE_CTRL_INVULN_EN.
module life_ctrl #(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned HIT_DIST      = 10,
   parameter int unsigned FREEZE_FRAMES = 60,
   parameter int unsigned INVULN_FRAMES = 90
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       restart,
   input  logic [9:0] pac_x,
   input  logic [9:0] pac_y,
   input  logic [9:0] ghost_x0,
   input  logic [9:0] ghost_x1,
   input  logic [9:0] ghost_x2,
   input  logic [9:0] ghost_x3,
   input  logic [9:0] ghost_y0,
   input  logic [9:0] ghost_y1,
   input  logic [9:0] ghost_y2,
   input  logic [9:0] ghost_y3,
   output logic       lifeDown,
   output logic [2:0] lives,
   output logic       freeze,
   output logic       game_over,
   output logic [1:0] hit_ghost
);

   localparam logic [1:0] PLAY    = 2'd0;
   localparam logic [1:0] RESPAWN = 2'd1;
   localparam logic [1:0] OVER    = 2'd2;

   // One counter width serves both the freeze and the grace timers.
   localparam int unsigned CNT_MAX = (FREEZE_FRAMES > INVULN_FRAMES) ? FREEZE_FRAMES
                                                                     : INVULN_FRAMES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    lives_q, lives_d;
   logic          life_down_q, life_down_d;
   logic [1:0]    hit_ghost_q, hit_ghost_d;
   logic [CW-1:0] grace_q, grace_d;
   logic          grace_clr;

   logic [9:0] gx [4];
   logic [9:0] gy [4];
   logic [3:0] contact;
   logic       any_hit;
   logic [1:0] hit_idx;

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   assign gx[0] = ghost_x0;
   assign gx[1] = ghost_x1;
   assign gx[2] = ghost_x2;
   assign gx[3] = ghost_x3;
   assign gy[0] = ghost_y0;
   assign gy[1] = ghost_y1;
   assign gy[2] = ghost_y2;
   assign gy[3] = ghost_y3;

   always_comb begin
      contact = '0;
      hit_idx = '0;
      for (int i = 0; i < 4; i++) begin
         contact[i] = (abs_diff(pac_x, gx[i]) <= 10'(HIT_DIST)) &&
                      (abs_diff(pac_y, gy[i]) <= 10'(HIT_DIST));
      end
      // Scan downwards so the lowest-index contact wins.
      for (int i = 3; i >= 0; i--) begin
         if (contact[i]) hit_idx = 2'(i);
      end
   end

   assign any_hit = |contact;

`ifdef LIFE_CTRL_INVULN_EN
   assign grace_clr = (grace_q == '0);
`else
   assign grace_clr = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lives_d     = lives_q;
      life_down_d = 1'b0;
      hit_ghost_d = hit_ghost_q;
      grace_d     = grace_q;
      if (restart) begin
         state_d     = PLAY;
         cnt_d       = '0;
         lives_d     = 3'(START_LIVES);
         hit_ghost_d = '0;
         grace_d     = '0;
      end else begin
         case (state_q)
            PLAY: begin
               if (!grace_clr) begin
                  grace_d = grace_q - 1'b1;
               end else if (any_hit && (lives_q != 3'd0)) begin
                  lives_d     = lives_q - 3'd1;
                  life_down_d = 1'b1;
                  hit_ghost_d = hit_idx;
                  if (lives_q == 3'd1) begin
                     state_d = OVER;
                  end else begin
                     state_d = RESPAWN;
                     cnt_d   = CW'(FREEZE_FRAMES - 1);
                  end
               end
            end
            RESPAWN: begin
               if (cnt_q == '0) begin
                  state_d = PLAY;
`ifdef LIFE_CTRL_INVULN_EN
                  grace_d = CW'(INVULN_FRAMES - 1);
`endif
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            OVER: ;
            default: state_d = PLAY;
         endcase
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= PLAY;
         cnt_q       <= '0;
         lives_q     <= 3'(START_LIVES);
         life_down_q <= 1'b0;
         hit_ghost_q <= '0;
         grace_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lives_q     <= lives_d;
         life_down_q <= life_down_d;
         hit_ghost_q <= hit_ghost_d;
         grace_q     <= grace_d;
      end
   end

   assign lifeDown  = life_down_q;
   assign lives     = lives_q;
   assign freeze    = (state_q != PLAY);
   assign game_over = (state_q == OVER);
   assign hit_ghost = hit_ghost_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Scoreboard bench for life_ctrl: directed game scenarios plus random positions, checked
// against a frame-by-frame game model. Honours LIFE_CTRL_INVULN_EN like the design.
module tb_life_ctrl;

   localparam int START = 3;
   localparam int HIT   = 10;
   localparam int FRZ   = 60;
   localparam int INV   = 90;

   typedef struct packed {
      logic [2:0] lives;
      logic       freeze;
      logic       game_over;
      logic       life_down;
      logic [1:0] hit_ghost;
   } obs_t;

   logic       frame_clk = 1'b0;
   logic       Reset, restart;
   logic [9:0] pac_x, pac_y;
   logic [9:0] ghost_x0, ghost_x1, ghost_x2, ghost_x3;
   logic [9:0] ghost_y0, ghost_y1, ghost_y2, ghost_y3;
   logic       lifeDown, freeze, game_over;
   logic [2:0] lives;
   logic [1:0] hit_ghost;

   life_ctrl #(
      .START_LIVES  (START),
      .HIT_DIST     (HIT),
      .FREEZE_FRAMES(FRZ),
      .INVULN_FRAMES(INV)
   ) dut (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .restart  (restart),
      .pac_x    (pac_x),
      .pac_y    (pac_y),
      .ghost_x0 (ghost_x0),
      .ghost_x1 (ghost_x1),
      .ghost_x2 (ghost_x2),
      .ghost_x3 (ghost_x3),
      .ghost_y0 (ghost_y0),
      .ghost_y1 (ghost_y1),
      .ghost_y2 (ghost_y2),
      .ghost_y3 (ghost_y3),
      .lifeDown (lifeDown),
      .lives    (lives),
      .freeze   (freeze),
      .game_over(game_over),
      .hit_ghost(hit_ghost)
   );

   always #5 frame_clk = ~frame_clk;

   int   px, py;
   int   gx [4];
   int   gy [4];
   obs_t exp_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game model: lives left, frames of freeze remaining, grace edges remaining.
   int m_lives, m_frz, m_grace, m_hg;
   bit m_over;

   function automatic obs_t actual();
      return {lives, freeze, game_over, lifeDown, hit_ghost};
   endfunction

   function automatic obs_t model_obs(input bit pulse);
      obs_t o;
      o.lives     = 3'(m_lives);
      o.freeze    = m_over || (m_frz > 0);
      o.game_over = m_over;
      o.life_down = pulse;
      o.hit_ghost = 2'(m_hg);
      return o;
   endfunction

   function automatic bit touching(input int i);
      int dx = px - gx[i];
      int dy = py - gy[i];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (dx <= HIT) && (dy <= HIT);
   endfunction

   task automatic model_reset();
      m_lives = START; m_frz = 0; m_grace = 0; m_hg = 0; m_over = 0;
   endtask

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got lives=%0d freeze=%b over=%b lifeDown=%b hit=%0d, expected lives=%0d freeze=%b over=%b lifeDown=%b hit=%0d",
                  name, $time, act.lives, act.freeze, act.game_over, act.life_down,
                  act.hit_ghost, exp.lives, exp.freeze, exp.game_over, exp.life_down,
                  exp.hit_ghost);
      end
   endtask

   // One frame: apply inputs at the falling edge and predict the state after the next rise.
   task automatic drive(input bit rs, input bit rst);
      bit pulse = 0;
      int first = -1;
      @(negedge frame_clk);
      pac_x = 10'(px); pac_y = 10'(py);
      ghost_x0 = 10'(gx[0]); ghost_x1 = 10'(gx[1]);
      ghost_x2 = 10'(gx[2]); ghost_x3 = 10'(gx[3]);
      ghost_y0 = 10'(gy[0]); ghost_y1 = 10'(gy[1]);
      ghost_y2 = 10'(gy[2]); ghost_y3 = 10'(gy[3]);
      restart = rs;
      Reset   = rst;
      if (rst) begin
         model_reset();
         #1 check("async_reset", actual(), model_obs(0));
      end else begin
         for (int i = 0; i < 4; i++) if (first < 0 && touching(i)) first = i;
         if (rs) begin
            model_reset();
         end else if (m_over) begin
         end else if (m_frz > 0) begin
            m_frz--;
`ifdef LIFE_CTRL_INVULN_EN
            // Grace lets lifeDown first reappear in PLAY frame INV+1.
            if (m_frz == 0) m_grace = INV - 1;
`endif
         end else if (m_grace > 0) begin
            m_grace--;
         end else if (first >= 0) begin
            m_lives--;
            pulse = 1;
            m_hg  = first;
            if (m_lives == 0) m_over = 1;
            else m_frz = FRZ;
         end
         exp_q.push_back(model_obs(pulse));
      end
   endtask

   task automatic set_far();
      for (int i = 0; i < 4; i++) begin
         gx[i] = 600 + 80 * i;
         gy[i] = 900;
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
   endfunction

   initial begin
      obs_t e;
      forever begin
         @(posedge frame_clk);
         #1;
         if (!Reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame", actual(), e);
         end
      end
   end

   initial begin
      Reset = 1'b1; restart = 1'b0;
      px = 144; py = 300;
      set_far();
      model_reset();
      drive(0, 1);
      drive(0, 1);

      // Hit, then reset partway through the freeze.
      gx[0] = 144; gy[0] = 305;
      repeat (30) drive(0, 0);
      drive(0, 1);
      drive(0, 1);

      // Held contact through a full respawn.
      repeat (160) drive(0, 0);

      // Restart colliding with contact.
      drive(1, 0);

      // Distance boundary and lowest-index priority.
      px = 100; py = 100;
      set_far();
      gx[2] = 111; gy[2] = 100;
      repeat (2) drive(0, 0);
      gx[2] = 110;
      drive(0, 0);
      drive(1, 0);
      set_far();
      gx[1] = 95;  gy[1] = 108;
      gx[3] = 100; gy[3] = 90;
      drive(0, 0);
      drive(1, 0);

      // Run down to game over and keep touching.
      set_far();
      gx[0] = 104; gy[0] = 96;
      repeat (350) drive(0, 0);
      drive(1, 0);
      set_far();
      repeat (3) drive(0, 0);

      // Random play.
      for (int n = 0; n < 3000; n++) begin
         px = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 1023 : 0)
                                          : int'($urandom_range(0, 1023));
         py = int'($urandom_range(0, 1023));
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               gx[i] = clamp(px + int'($urandom_range(0, 30)) - 15);
               gy[i] = clamp(py + int'($urandom_range(0, 30)) - 15);
            end else begin
               gx[i] = int'($urandom_range(0, 1023));
               gy[i] = int'($urandom_range(0, 1023));
            end
         end
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
      end

      repeat (2) @(posedge frame_clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked frames, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
